// File: rtl/reg_file_pkg.sv
// Shared constants and types for the multi-read-port register file.
// Default geometry and the clear-sequencer state encoding.
package reg_file_pkg;

  localparam int RF_DW    = 16;
  localparam int RF_DEPTH = 128;
  localparam int RF_NRD   = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } rf_seq_t;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer: walks every entry writing zero after reset or on
// request, then parks in IDLE until the next init_req.
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init_req_i,
  output logic          init_busy_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_seq_t       state_q;
  logic [AW-1:0] cnt_q;
  logic          busy_q;

  // CLEAR/IDLE FSM with address counter and registered busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        CLEAR: begin
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        IDLE: begin
          if (init_req_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= CLEAR;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign init_busy_o = busy_q;
  assign clr_we_o    = (state_q == CLEAR);
  assign clr_addr_o  = cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// Flop-based register file, one write port, NRD registered read ports,
// hardware clear. REG_FILE_MP_BYPASS_EN adds same-cycle write forwarding.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DW    = RF_DW,
  parameter int DEPTH = RF_DEPTH,
  parameter int NRD   = RF_NRD,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  input  logic              init_req,
  output logic              init_busy,
  output logic              addr_err
);

  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

  logic          busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;

  reg_file_clr_seq #(
    .DEPTH (DEPTH)
  ) u_clr_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_req_i  (init_req),
    .init_busy_o (busy),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr)
  );

  assign init_busy = busy;

  logic          wr_ok;
  logic          ext_we;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  assign wr_ok  = ({1'b0, wr_addr} < LIMIT);
  assign ext_we = ~busy & wr_en & wr_ok;
  assign we     = clr_we | ext_we;
  assign waddr  = clr_we ? clr_addr : wr_addr;
  assign wdata  = clr_we ? '0 : wr_data;

  logic [DW-1:0] mem_q [DEPTH];

  // Storage array: single merged write port, intentionally not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  logic [NRD-1:0] rd_ok;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rd_d;
    logic [DW-1:0] rd_q;

    assign ra       = rd_addr[k*AW +: AW];
    assign rd_ok[k] = ({1'b0, ra} < LIMIT);

    // Next read value: zero while clearing or out of range
    always_comb begin
      rd_d = rd_q;
      if (rd_en[k]) begin
        if (busy || !rd_ok[k]) begin
          rd_d = '0;
`ifdef REG_FILE_MP_BYPASS_EN
        end else if (ext_we && (wr_addr == ra)) begin
          rd_d = wr_data;
`endif
        end else begin
          rd_d = mem_q[ra];
        end
      end
    end

    // Read register, reset to zero
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_d;
      end
    end

    assign rd_data[k*DW +: DW] = rd_q;
  end

  logic err_d;
  logic err_q;

  assign err_d = ~busy & ((wr_en & ~wr_ok) | (|(rd_en & ~rd_ok)));

  // Out-of-range access flag, one-cycle registered pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign addr_err = err_q;

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file: one synchronous write port, `NRD` registered read ports, configurable data width and depth, built from flops. Adds a hardware clear sequencer that zeroes every entry after reset or on request, with out-of-range address detection. Sits between the instruction decode stage (read addresses) and the writeback stage (write port). It replaces per-read-port SRAM macro duplication in the datapath.

## Interface
- `DW`, 16, data width in bits (1..64)
- `DEPTH`, 128, number of entries (2..256, need not be a power of two)
- `NRD`, 2, number of read ports (1..4)
- `AW`, `$clog2(DEPTH)`, address width; derived, not overridden
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `wr_en`  in  1  write strobe
- `wr_addr`  in  AW  write address
- `wr_data`  in  DW  write data
- `rd_en`  in  NRD  per-port read strobe
- `rd_addr`  in  NRD*AW  packed read addresses; port k at [k*AW +: AW]
- `rd_data`  out  NRD*DW  packed registered read data; port k at [k*DW +: DW]
- `init_req`  in  1  request a full clear; sampled only in IDLE
- `init_busy`  out  1  clear sequence in progress
- `addr_err`  out  1  one-cycle pulse on an out-of-range access

## Operation
- The storage array is not reset. Only the sequencer, read registers and `addr_err` are reset.
- Sequencer states are CLEAR and IDLE. The reset state is CLEAR with the counter at 0.
- CLEAR writes 0 to entry `cnt` each cycle and increments `cnt`. After writing entry DEPTH-1 it moves to IDLE, so CLEAR lasts exactly DEPTH cycles.
- In IDLE, `init_req`=1 moves the sequencer to CLEAR with `cnt`=0. `init_req` is ignored while in CLEAR.
- While `init_busy`=1:
  - external writes are dropped;
  - read registers with `rd_en` set load 0;
  - `addr_err` stays 0.
- Write: in IDLE with `wr_en`=1 and `wr_addr`<DEPTH, `mem[wr_addr]` takes `wr_data` at the clock edge.
- Read port k: with `rd_en[k]`=1, the read register loads `mem[rd_addr_k]` at the clock edge. With `rd_en[k]`=0, the register holds its value.
- Out of range: an address ≥ DEPTH is out of range.
  - An out-of-range write is dropped.
  - An out-of-range read loads 0.
  - Either case raises `addr_err` for one cycle. It is registered, so it appears the cycle after the access.
- Read ports are independent. Multiple ports may read the same address in the same cycle.

## Timing
- Reset values: `rd_data`=0 on all ports, `init_busy`=1, `addr_err`=0.
- Read latency is 1 cycle. With address presented in cycle N and `rd_en` set, data is valid after edge N+1 and held until the next enabled read.
- Write latency is 1 cycle. A write in cycle N is visible to a read issued in cycle N+1.
- Same-address read and write in cycle N: see Configuration.
- Reset mid-CLEAR or mid-IDLE asynchronously forces the CLEAR state with `cnt`=0. The full DEPTH-cycle clear restarts after `rst_n` rises.
- `init_busy` falls at the edge ending the last clear write. A write in that following cycle is accepted.

## Configuration
- `REG_FILE_MP_BYPASS_EN` enables write-to-read forwarding.
- Defined: in IDLE, a read in cycle N to the address of an in-range write in the same cycle N returns `wr_data`. This gives zero-bubble writeback-to-decode forwarding on every port.
- Undefined: the same-cycle read returns the old contents. Forwarding logic is absent.

## Structure
- Shared package `reg_file_pkg` holds:
  - the default constants `RF_DW`, `RF_DEPTH`, `RF_NRD`;
  - the sequencer state typedef `rf_seq_t` (CLEAR, IDLE).
- Sub-module `reg_file_clr_seq` contains the CLEAR/IDLE FSM and counter. It outputs `init_busy`, a clear-write enable and the clear address.
- The top level muxes the clear write and the external write into a single internal write port. It also contains the array, the read registers and the optional bypass.

## Test plan
- Reset release, default params → `init_busy`=1 for exactly 128 cycles, then 0. Writing 16'hA5A5 to address 5 during busy is dropped, and a read of address 5 after busy returns 16'h0000.
- After IDLE, write 16'h1234 to address 7 in cycle N, then read port 0 and port 1 both at address 7 in cycle N+1 → both ports show 16'h1234 after edge N+2.
- Read and write of address 3 (16'hBEEF, previous value 16'h0001) in the same cycle → 16'hBEEF with `REG_FILE_MP_BYPASS_EN`, 16'h0001 without it.
- DEPTH=100: write to address 100 → `addr_err` pulses one cycle and entry contents are unchanged. Read of address 120 → 0 and `addr_err` pulses.
- Fill entries 0..127 with their index, then pulse `init_req` → `init_busy` high for 128 cycles, and every address then reads 0.
- Assert `rst_n`=0 at cycle 40 of a clear → `rd_data`=0 and `init_busy`=1 immediately. After release, `init_busy` stays high for a full 128 cycles.
